// File: rtl/spm_serial_ctrl_if.sv
// spm_serial_ctrl_if: bundles every non-clock signal of spm_serial_ctrl.
//
// Handshake rule, shared by the operand (in_*) and product (out_*) channels:
//   a transfer happens on a rising clk edge where valid && ready are both 1.
//   valid must not wait for ready. Once valid is raised, the source keeps its
//   payload stable until that transfer edge. The ready and valid outputs of the
//   controller come straight from state registers and are never a function of
//   the same-cycle in_valid or out_ready.
//
// Signals:
//   in_valid/in_ready/in_x/in_y  operand channel (y is sent out LSB first)
//   out_valid/out_ready/out_p    product channel, bit 0 = first bit captured
//   spm_x/spm_y/spm_rst/spm_p    multiplier side (spm_rst is active-low)
// Modports:
//   slave  - the controller
//   master - the environment: operand source, product sink and multiplier
interface spm_serial_ctrl_if #(
  parameter int WIDTH  = 32,
  parameter int YWIDTH = 32
);
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          in_x;
  logic [YWIDTH-1:0]         in_y;
  logic [WIDTH-1:0]          spm_x;
  logic                      spm_y;
  logic                      spm_rst;
  logic                      spm_p;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH+YWIDTH-1:0]   out_p;

  modport slave (
    input  in_valid, in_x, in_y, spm_p, out_ready,
    output in_ready, spm_x, spm_y, spm_rst, out_valid, out_p
  );

  modport master (
    output in_valid, in_x, in_y, spm_p, out_ready,
    input  in_ready, spm_x, spm_y, spm_rst, out_valid, out_p
  );
endinterface

// File: rtl/spm_serial_ctrl.sv
// spm_serial_ctrl: serial-side controller for the spm serial-parallel multiplier.
//   Accepts (x, y), holds x on spm_x, shifts y out on spm_y LSB first, then
//   pads up to WIDTH+YWIDTH bits. It collects spm_p into out_p and returns the
//   product. Only one operation is in flight at a time.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-low
//   bus        spm_serial_ctrl_if.slave (operand, product and multiplier signals)
//   dbg_state  current FSM state (IDLE=0, CLEAR=1, SHIFT=2, DRAIN=3, DONE=4)
//
// Build option:
//   SPM_CTRL_SIGNED_EN - when defined, the pad bit is y's sign bit.
//                        The product is then two's-complement signed.
//                        When undefined, the pad bit is 0 and the product is unsigned.
module spm_serial_ctrl #(
  parameter int WIDTH  = 32,
  parameter int YWIDTH = 32,
  parameter int P_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  spm_serial_ctrl_if.slave   bus,
  output logic [2:0]         dbg_state
);
  localparam int N  = WIDTH + YWIDTH;
  localparam int CW = $clog2(N + P_LAT + 1);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(N + P_LAT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     cnt;
  logic [YWIDTH-1:0] y_sr;
  logic [WIDTH-1:0]  x_q;
  logic [N-1:0]      p_sr;
  logic              pad_bit;
  logic              cap_en;

  // The MSB is refilled with the pad bit on every shift. In the signed build,
  // that keeps the sign bit in place, so the shift is arithmetic.
`ifdef SPM_CTRL_SIGNED_EN
  assign pad_bit = y_sr[YWIDTH-1];
`else
  assign pad_bit = 1'b0;
`endif

  // cnt runs without a break through SHIFT (0..N-1) and DRAIN (N..N+P_LAT-1).
  // The bit driven at count k returns at count k+P_LAT. So capture covers
  // every count from P_LAT onward. The int cast avoids an always-true
  // unsigned compare when P_LAT is 0.
  assign cap_en = ((state == SHIFT) || (state == DRAIN)) && (int'(cnt) >= P_LAT);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.in_valid) state_nxt = CLEAR;
      CLEAR: state_nxt = SHIFT;
      SHIFT: if (cnt == SHIFT_LAST) state_nxt = (P_LAT == 0) ? DONE : DRAIN;
      DRAIN: if (cnt == DRAIN_LAST) state_nxt = DONE;
      DONE:  if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: every one is decoded from registered state only
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.spm_rst   = (state == SHIFT) || (state == DRAIN);
    bus.spm_y     = (state == SHIFT) && y_sr[0];
    bus.spm_x     = x_q;
    bus.out_p     = p_sr;
    dbg_state     = state;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt  <= '0;
      y_sr <= '0;
      x_q  <= '0;
      p_sr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x_q  <= bus.in_x;
            y_sr <= bus.in_y;
          end
        end
        CLEAR: cnt <= '0;
        SHIFT: begin
          cnt  <= cnt + CW'(1);
          y_sr <= {pad_bit, y_sr[YWIDTH-1:1]};
        end
        DRAIN: cnt <= cnt + CW'(1);
        default: ;
      endcase
      // Right shift with entry at the MSB. After N captures, the first bit is at bit 0.
      if (cap_en) p_sr <= {bus.spm_p, p_sr[N-1:1]};
    end
  end
endmodule

// File: tb/tb_spm_serial_ctrl.sv
// tb_spm_serial_ctrl: bench for spm_serial_ctrl with WIDTH=YWIDTH=4.
// It builds three controller instances, each paired with a behavioural spm
// multiplier: inst[0] has P_LAT=1, inst[1] has P_LAT=0 and inst[2] has P_LAT=3.
// Expected products are computed arithmetically when operands are driven.
// They are queued, then popped when out_valid appears.
module tb_spm_serial_ctrl;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] in_valid;
  logic [3:0] in_x;
  logic [3:0] in_y;
  logic       out_ready;

  logic [2:0] in_ready_w;
  logic [2:0] out_valid_w;
  logic [2:0] spm_y_w;
  logic [2:0] spm_rst_w;
  logic [7:0] out_p_w [3];
  logic [3:0] spm_x_w [3];
  logic [2:0] dbg_w   [3];

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_lat_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Clock / reset
  always #5 clk = ~clk;

  // DUT instances with behavioural multipliers
  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int PL = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

    spm_serial_ctrl_if #(.WIDTH(4), .YWIDTH(4)) bus ();
    logic [2:0] dbg;

    spm_serial_ctrl #(.WIDTH(4), .YWIDTH(4), .P_LAT(PL)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg)
    );

    assign bus.in_valid  = in_valid[g];
    assign bus.in_x      = in_x;
    assign bus.in_y      = in_y;
    assign bus.out_ready = out_ready;

    assign in_ready_w[g]  = bus.in_ready;
    assign out_valid_w[g] = bus.out_valid;
    assign spm_y_w[g]     = bus.spm_y;
    assign spm_rst_w[g]   = bus.spm_rst;
    assign out_p_w[g]     = bus.out_p;
    assign spm_x_w[g]     = bus.spm_x;
    assign dbg_w[g]       = dbg;

    // Multiplier model: product bit k = bit k of x * (y bits received so far).
    // The result appears PL cycles after y bit k is driven.
    logic [7:0] m_y;
    logic [7:0] y_nx;
    logic [7:0] m_xe;
    logic [7:0] prod;
    logic [3:0] m_k;
    logic [3:0] pipe;
    logic       p0;

`ifdef SPM_CTRL_SIGNED_EN
    assign m_xe = {{4{bus.spm_x[3]}}, bus.spm_x};
`else
    assign m_xe = {4'b0, bus.spm_x};
`endif

    always_comb begin
      y_nx = m_y;
      if (m_k < 4'd8) y_nx[m_k[2:0]] = bus.spm_y;
      prod = m_xe * y_nx;
      p0   = (m_k < 4'd8) ? prod[m_k[2:0]] : 1'b0;
    end

    always @(posedge clk) begin
      if (!bus.spm_rst) begin
        m_y  <= '0;
        m_k  <= '0;
        pipe <= '0;
      end else begin
        m_y  <= y_nx;
        m_k  <= m_k + 4'd1;
        pipe <= {pipe[2:0], p0};
      end
    end

    if (PL == 0) begin : g_p0
      assign bus.spm_p = p0;
    end else begin : g_pd
      assign bus.spm_p = pipe[PL-1];
    end
  end

  function automatic logic [W-1:0] exp_prod(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] xe;
    logic [7:0] ye;
`ifdef SPM_CTRL_SIGNED_EN
    xe = {{4{x[3]}}, x};
    ye = {{4{y[3]}}, y};
`else
    xe = {4'b0, x};
    ye = {4'b0, y};
`endif
    return xe * ye;
  endfunction

  function automatic logic [W-1:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  // Driver tasks. Each is entered at a negedge while inst[i] is in IDLE.
  // drive_op returns at the negedge of cycle 1, where cycle 0 is the accept cycle.
  task automatic drive_op(input int i, input logic [3:0] x, input logic [3:0] y);
    in_x = x;
    in_y = y;
    in_valid[i] = 1'b1;
    exp_q.push_back(exp_prod(x, y));
    @(negedge clk);
    in_valid[i] = 1'b0;
  endtask

  // Wait for out_valid on inst[i]. lat returns the cycle at which it was first seen.
  task automatic wait_valid(input int i, input int start, input int budget, output int lat);
    lat = start;
    while (!out_valid_w[i] && lat < budget) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    logic [16:0] got;
    rst = 1'b0;
    in_valid = '0;
    in_x = '0;
    in_y = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    got = {in_ready_w[0], out_valid_w[0], out_p_w[0], spm_x_w[0], spm_y_w[0], spm_rst_w[0], 1'b0};
    n_cmp++;
    if (got !== {1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected %h", got, 17'h10000);
    end
    n_cmp++;
    if (dbg_w[0] !== 3'd0) begin
      n_err++;
      $display("FAIL reset_state: got %0d expected 0", dbg_w[0]);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    int ir_bad;
    logic [W-1:0] e;
    out_ready = 1'b1;
    n_cmp++;
    if (in_ready_w[0] !== 1'b1) begin
      n_err++;
      $display("FAIL basic_ready_idle: got %b expected 1", in_ready_w[0]);
    end
    drive_op(0, 4'd3, 4'd5);
    lat = 1;
    ir_bad = 0;
    while (!out_valid_w[0] && lat < 40) begin
      if (in_ready_w[0] !== 1'b0) ir_bad++;
      @(negedge clk);
      lat++;
    end
    if (in_ready_w[0] !== 1'b0) ir_bad++;
    n_cmp++;
    if (lat != 11) begin
      n_err++;
      $display("FAIL basic_latency: got %0d expected 11", lat);
    end
    n_cmp++;
    if (ir_bad != 0) begin
      n_err++;
      $display("FAIL basic_in_ready_busy: got %0d high cycles expected 0", ir_bad);
    end
    e = pop_exp();
    n_cmp++;
    if (out_p_w[0] !== e) begin
      n_err++;
      $display("FAIL basic_out_p: got %h expected %h", out_p_w[0], e);
    end
    @(negedge clk);
    n_cmp++;
    if ({out_valid_w[0], in_ready_w[0]} !== 2'b01) begin
      n_err++;
      $display("FAIL basic_return_idle: got valid/ready %b expected 01", {out_valid_w[0], in_ready_w[0]});
    end
  endtask

  task automatic test_all_ones();
    int lat;
    logic [W-1:0] e;
    out_ready = 1'b1;
    drive_op(0, 4'hF, 4'hF);
    wait_valid(0, 1, 40, lat);
    e = pop_exp();
    n_cmp++;
    if (out_p_w[0] !== e) begin
      n_err++;
      $display("FAIL all_ones_out_p: got %h expected %h", out_p_w[0], e);
    end
    @(negedge clk);
  endtask

  task automatic test_hold();
    int lat;
    int bad;
    logic [W-1:0] e;
    out_ready = 1'b0;
    drive_op(0, 4'd7, 4'd6);
    wait_valid(0, 1, 40, lat);
    n_cmp++;
    if (lat != 11) begin
      n_err++;
      $display("FAIL hold_latency: got %0d expected 11", lat);
    end
    e = pop_exp();
    bad = 0;
    repeat (20) begin
      if (out_valid_w[0] !== 1'b1 || out_p_w[0] !== e) bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad != 0 || out_p_w[0] !== e) begin
      n_err++;
      $display("FAIL hold_stable: got %0d bad cycles, out_p %h expected %h", bad, out_p_w[0], e);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({out_valid_w[0], in_ready_w[0]} !== 2'b01) begin
      n_err++;
      $display("FAIL hold_release: got valid/ready %b expected 01", {out_valid_w[0], in_ready_w[0]});
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [W-1:0] e;
    out_ready = 1'b1;
    drive_op(0, 4'd9, 4'd11);
    repeat (4) @(negedge clk);   // now in cycle 5 = SHIFT cycle 3
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({in_ready_w[0], out_valid_w[0], out_p_w[0]} !== {1'b1, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL midreset_state: got ready %b valid %b out_p %h expected 1 0 00",
               in_ready_w[0], out_valid_w[0], out_p_w[0]);
    end
    rst = 1'b1;
    void'(exp_q.pop_back());     // aborted operation produces no result
    drive_op(0, 4'd2, 4'd2);
    wait_valid(0, 1, 40, lat);
    e = pop_exp();
    n_cmp++;
    if (lat != 11 || out_p_w[0] !== e) begin
      n_err++;
      $display("FAIL midreset_next_op: got lat %0d out_p %h expected 11 %h", lat, out_p_w[0], e);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [W-1:0] e;
    out_ready = 1'b1;
    in_x = 4'd1;
    in_y = 4'd1;
    in_valid[0] = 1'b1;
    exp_q.push_back(exp_prod(4'd1, 4'd1));
    @(negedge clk);
    in_x = 4'd9;
    in_y = 4'd9;
    exp_q.push_back(exp_prod(4'd9, 4'd9));
    wait_valid(0, 1, 40, lat);
    e = pop_exp();
    n_cmp++;
    if (lat != 11 || out_p_w[0] !== e) begin
      n_err++;
      $display("FAIL b2b_first: got lat %0d out_p %h expected 11 %h", lat, out_p_w[0], e);
    end
    @(negedge clk);
    n_cmp++;
    if ({out_valid_w[0], in_ready_w[0]} !== 2'b01) begin
      n_err++;
      $display("FAIL b2b_accept_slot: got valid/ready %b expected 01", {out_valid_w[0], in_ready_w[0]});
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready_w[0] !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_second_accepted: got in_ready %b expected 0", in_ready_w[0]);
    end
    wait_valid(0, 13, 60, lat);
    e = pop_exp();
    n_cmp++;
    if (lat != 23 || out_p_w[0] !== e) begin
      n_err++;
      $display("FAIL b2b_second: got lat %0d out_p %h expected 23 %h", lat, out_p_w[0], e);
    end
    in_valid[0] = 1'b0;
    @(negedge clk);
    repeat (12) @(negedge clk);  // drain any third accept before moving on
    exp_q.delete();
  endtask

  task automatic test_plat();
    int lat1;
    int lat2;
    int c;
    logic [W-1:0] e;
    out_ready = 1'b1;
    in_x = 4'd3;
    in_y = 4'd5;
    in_valid[1] = 1'b1;
    in_valid[2] = 1'b1;
    exp_lat_q.push_back(exp_prod(4'd3, 4'd5));
    exp_lat_q.push_back(exp_prod(4'd3, 4'd5));
    @(negedge clk);
    in_valid[1] = 1'b0;
    in_valid[2] = 1'b0;
    lat1 = -1;
    lat2 = -1;
    c = 1;
    while ((lat1 < 0 || lat2 < 0) && c < 40) begin
      if (out_valid_w[1] && lat1 < 0) begin
        lat1 = c;
        e = (exp_lat_q.size() != 0) ? exp_lat_q.pop_front() : 'x;
        n_cmp++;
        if (out_p_w[1] !== e) begin
          n_err++;
          $display("FAIL plat0_out_p: got %h expected %h", out_p_w[1], e);
        end
      end
      if (out_valid_w[2] && lat2 < 0) begin
        lat2 = c;
        e = (exp_lat_q.size() != 0) ? exp_lat_q.pop_front() : 'x;
        n_cmp++;
        if (out_p_w[2] !== e) begin
          n_err++;
          $display("FAIL plat3_out_p: got %h expected %h", out_p_w[2], e);
        end
      end
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (lat1 != 10) begin
      n_err++;
      $display("FAIL plat0_latency: got %0d expected 10", lat1);
    end
    n_cmp++;
    if (lat2 != 13) begin
      n_err++;
      $display("FAIL plat3_latency: got %0d expected 13", lat2);
    end
  endtask

  task automatic test_random();
    int lat;
    int hold;
    logic [3:0] x;
    logic [3:0] y;
    logic [W-1:0] e;
    for (int k = 0; k < 8; k++) begin
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      hold = $urandom_range(0, 3);
      out_ready = (hold == 0);
      drive_op(0, x, y);
      wait_valid(0, 1, 40, lat);
      repeat (hold) @(negedge clk);
      e = pop_exp();
      n_cmp++;
      if (lat != 11 || out_valid_w[0] !== 1'b1 || out_p_w[0] !== e) begin
        n_err++;
        $display("FAIL random_op%0d: x=%h y=%h got lat %0d out_p %h expected 11 %h",
                 k, x, y, lat, out_p_w[0], e);
      end
      out_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_ones();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_plat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
